// File: rtl/aes_gcm_sched.sv
// Shares one aes_api GCM core between N_REQ block requesters: packet-level round-robin,
// issue pacing, credit-limited in-flight count and in-order routing of results back.
module aes_gcm_sched #(
  parameter int N_REQ        = 2,
  parameter int MAX_INFLIGHT = 8,
  parameter int MIN_GAP      = 2,
  parameter int BYPASS_W     = 289,
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int IFW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*128-1:0]        req_data,
  input  logic [N_REQ*BYPASS_W-1:0]   req_bypass,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        aes_new,
  output logic                        aes_last,
  output logic [127:0]                aes_plain_text,
  output logic [BYPASS_W-1:0]         aes_bypass_text,
  input  logic                        aes_cp_ready,
  input  logic [127:0]                aes_cipher_text,
  output logic                        rsp_valid,
  output logic [IDW-1:0]              rsp_id,
  output logic                        rsp_last,
  output logic [127:0]                rsp_data,
  output logic [IFW-1:0]              inflight,
  output logic                        err_underflow
);

  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [0:0]     ST_IDLE   = 1'b0;
  localparam logic [0:0]     ST_LOCKED = 1'b1;
  localparam logic [IFW-1:0] CAP       = IFW'(MAX_INFLIGHT);
  localparam logic [GW-1:0]  GAP_LOAD  = GW'(MIN_GAP - 1);

  function automatic logic [IDW-1:0] id_next(input logic [IDW-1:0] id);
    return (int'(id) == N_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % N_REQ);
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (int'(p) == MAX_INFLIGHT - 1) ? '0 : p + 1'b1;
  endfunction

  logic [0:0]     state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] rr_ptr;
  logic [GW-1:0]  gap_cnt;
  logic [IFW-1:0] cnt;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           err_uf;
  logic [IDW:0]   tag_mem [MAX_INFLIGHT];

  logic [IDW-1:0] grant;
  logic           grant_vld;
  logic           can_issue;
  logic           accept;
  logic           acc_last;
  logic           pop;

  logic                iss_vld_p1;
  logic                iss_last_p1;
  logic [127:0]        iss_data_p1;
  logic [BYPASS_W-1:0] iss_bp_p1;
  logic                rsp_vld_p1;
  logic [IDW-1:0]      rsp_id_p1;
  logic                rsp_last_p1;
  logic [127:0]        rsp_data_p1;

  // Descending scan so the lowest offset from rr_ptr wins without an early exit.
  always_comb begin
    grant     = owner;
    grant_vld = 1'b0;
    if (state == ST_LOCKED) begin
      grant_vld = req_valid[owner];
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (req_valid[rr_idx(rr_ptr, k)]) begin
          grant     = rr_idx(rr_ptr, k);
          grant_vld = 1'b1;
        end
      end
    end
  end

  // Credit test uses the registered count, so a same-cycle return frees a slot only next cycle.
  assign can_issue = (gap_cnt == '0) && (cnt < CAP);
  assign accept    = reset && can_issue && grant_vld;
  assign acc_last  = req_last[grant];
  assign req_ready = accept ? (N_REQ'(1) << grant) : '0;
  assign pop       = aes_cp_ready && (cnt != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      gap_cnt <= '0;
      cnt     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_uf  <= 1'b0;
    end else begin
      if (accept) begin
        gap_cnt <= GAP_LOAD;
        if (acc_last) begin
          state  <= ST_IDLE;
          rr_ptr <= id_next(grant);
        end else begin
          state <= ST_LOCKED;
          owner <= grant;
        end
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      if (accept) wr_ptr <= ptr_next(wr_ptr);
      if (pop)    rd_ptr <= ptr_next(rd_ptr);
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (aes_cp_ready && (cnt == '0)) err_uf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr] <= {grant, acc_last};
  end

  // Stage p1: issue registers toward aes_api, and returned-result registers toward requesters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss_vld_p1  <= 1'b0;
      iss_last_p1 <= 1'b0;
      iss_data_p1 <= '0;
      iss_bp_p1   <= '0;
      rsp_vld_p1  <= 1'b0;
      rsp_id_p1   <= '0;
      rsp_last_p1 <= 1'b0;
      rsp_data_p1 <= '0;
    end else begin
      iss_vld_p1  <= accept;
      iss_last_p1 <= accept && acc_last;
      if (accept) begin
        iss_data_p1 <= req_data[int'(grant)*128 +: 128];
        iss_bp_p1   <= req_bypass[int'(grant)*BYPASS_W +: BYPASS_W];
      end
      rsp_vld_p1 <= pop;
      if (pop) begin
        {rsp_id_p1, rsp_last_p1} <= tag_mem[rd_ptr];
        rsp_data_p1              <= aes_cipher_text;
      end
    end
  end

  assign aes_new         = iss_vld_p1;
  assign aes_last        = iss_last_p1;
  assign aes_plain_text  = iss_data_p1;
  assign aes_bypass_text = iss_bp_p1;
  assign rsp_valid       = rsp_vld_p1;
  assign rsp_id          = rsp_id_p1;
  assign rsp_last        = rsp_last_p1;
  assign rsp_data        = rsp_data_p1;
  assign inflight        = cnt;
  assign err_underflow   = err_uf;

endmodule
